// File: rtl/updown_counter.sv
// updown_counter
//
// N-bit synchronous up/down counter used as an index/address generator.
// Steps by one on every rising clock edge (no enable), upward when down=0
// and downward when down=1. At the range limits it either wraps modulo 2^N
// (WRAP=1) or holds at the limit (WRAP=0). In both cases, wrapped is raised
// for the cycle after the limit-crossing edge.
//
// Parameters:
//   N           counter width, 1..32
//   WRAP        1 = wrap around at limits, 0 = saturate at limits
//   RESET_VALUE value loaded on reset, 0..2^N-1
//
// Ports:
//   clk      in   clock, rising-edge active
//   rst_n    in   synchronous active-low reset
//   down     in   direction: 0 = up, 1 = down
//   count    out  registered counter value [N-1:0]
//   at_max   out  count == 2^N-1 (decode of the count register)
//   at_min   out  count == 0     (decode of the count register)
//   wrapped  out  registered pulse after a wrap or saturation attempt

module updown_counter #(
  parameter int          N           = 3,
  parameter int          WRAP        = 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         down,
  output logic [N-1:0] count,
  output logic         at_max,
  output logic         at_min,
  output logic         wrapped
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_MIN = '0;
  localparam logic [N-1:0] RST_VAL = RESET_VALUE[N-1:0];

  logic         hit_max;
  logic         hit_min;
  logic         at_limit;
  logic [N-1:0] count_step;
  logic [N-1:0] count_nxt;

  assign hit_max = (count == CNT_MAX);
  assign hit_min = (count == CNT_MIN);

  // A limit is only crossed when the step heads toward the limit we sit on.
  assign at_limit = down ? hit_min : hit_max;

  always_comb begin
    // Natural N-bit modular arithmetic already provides the wrap behaviour.
    count_step = down ? (count - N'(1)) : (count + N'(1));
    count_nxt  = count_step;
    if (at_limit && (WRAP == 0)) begin
      count_nxt = count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= RST_VAL;
      wrapped <= 1'b0;
    end else begin
      count   <= count_nxt;
      wrapped <= at_limit;
    end
  end

  assign at_max = hit_max;
  assign at_min = hit_min;

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // a: N=3 wrap, b: N=3 saturate, c: N=1 wrap, d: N=8 wrap, e: N=8 reset value 200
  logic       rst_a = 1'b0, down_a = 1'b0;
  logic [2:0] cnt_a;
  logic       max_a, min_a, wr_a;

  logic       rst_b = 1'b0, down_b = 1'b0;
  logic [2:0] cnt_b;
  logic       max_b, min_b, wr_b;

  logic       rst_c = 1'b0, down_c = 1'b0;
  logic [0:0] cnt_c;
  logic       max_c, min_c, wr_c;

  logic       rst_d = 1'b0, down_d = 1'b0;
  logic [7:0] cnt_d;
  logic       max_d, min_d, wr_d;

  logic       rst_e = 1'b0, down_e = 1'b0;
  logic [7:0] cnt_e;
  logic       max_e, min_e, wr_e;

  updown_counter #(.N(3), .WRAP(1), .RESET_VALUE(0)) u_a (
    .clk(clk), .rst_n(rst_a), .down(down_a), .count(cnt_a),
    .at_max(max_a), .at_min(min_a), .wrapped(wr_a));

  updown_counter #(.N(3), .WRAP(0), .RESET_VALUE(0)) u_b (
    .clk(clk), .rst_n(rst_b), .down(down_b), .count(cnt_b),
    .at_max(max_b), .at_min(min_b), .wrapped(wr_b));

  updown_counter #(.N(1), .WRAP(1), .RESET_VALUE(0)) u_c (
    .clk(clk), .rst_n(rst_c), .down(down_c), .count(cnt_c),
    .at_max(max_c), .at_min(min_c), .wrapped(wr_c));

  updown_counter #(.N(8), .WRAP(1), .RESET_VALUE(0)) u_d (
    .clk(clk), .rst_n(rst_d), .down(down_d), .count(cnt_d),
    .at_max(max_d), .at_min(min_d), .wrapped(wr_d));

  updown_counter #(.N(8), .WRAP(1), .RESET_VALUE(200)) u_e (
    .clk(clk), .rst_n(rst_e), .down(down_e), .count(cnt_e),
    .at_max(max_e), .at_min(min_e), .wrapped(wr_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_a;
    int dn_seq [7];
    dn_seq = '{4, 3, 2, 1, 0, 7, 6};

    // ---- A: reset held for two edges while down toggles
    rst_a = 1'b0; down_a = 1'b1; tick();
    down_a = 1'b0; tick();
    chk("a_rst_count",   32'(cnt_a), 0);
    chk("a_rst_at_min",  32'(min_a), 1);
    chk("a_rst_at_max",  32'(max_a), 0);
    chk("a_rst_wrapped", 32'(wr_a),  0);

    // ---- A: count up through the wrap, 9 edges
    rst_a = 1'b1; down_a = 1'b0;
    exp_a = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_a = (exp_a + 1) % 8;
      chk("a_up_count",   32'(cnt_a), 32'(exp_a));
      chk("a_up_at_max",  32'(max_a), 32'(exp_a == 7));
      chk("a_up_at_min",  32'(min_a), 32'(exp_a == 0));
      chk("a_up_wrapped", 32'(wr_a),  32'(exp_a == 0));
    end

    // ---- A: up to 5 then reverse with no hold cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_a = exp_a + 1;
      chk("a_up5_count", 32'(cnt_a), 32'(exp_a));
    end
    down_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("a_dn_count",   32'(cnt_a), 32'(dn_seq[i]));
      chk("a_dn_wrapped", 32'(wr_a),  32'(dn_seq[i] == 7));
    end

    // ---- A: reset mid-count at 4 discards the pending step
    rst_a = 1'b0; tick();
    chk("a_rst2_count", 32'(cnt_a), 0);
    rst_a = 1'b1; down_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("a_pre_count", 32'(cnt_a), 32'(i));
    end
    rst_a = 1'b0; tick();
    chk("a_mid_rst_count",   32'(cnt_a), 0);
    chk("a_mid_rst_wrapped", 32'(wr_a),  0);
    rst_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("a_resume_count", 32'(cnt_a), 32'(i));
    end

    // ---- B: saturation, 10 up edges
    rst_b = 1'b0; tick(); tick();
    chk("b_rst_count", 32'(cnt_b), 0);
    rst_b = 1'b1; down_b = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("b_sat_count",   32'(cnt_b), 32'((i < 7) ? i : 7));
      chk("b_sat_wrapped", 32'(wr_b),  32'(i > 7));
    end
    chk("b_sat_at_max", 32'(max_b), 1);
    down_b = 1'b1;
    tick();
    chk("b_rev_count",   32'(cnt_b), 6);
    chk("b_rev_wrapped", 32'(wr_b),  0);
    for (int i = 5; i >= 0; i--) begin
      tick();
      chk("b_dn_count", 32'(cnt_b), 32'(i));
    end
    chk("b_min_wrapped", 32'(wr_b), 0);
    tick();
    chk("b_minsat_count",   32'(cnt_b), 0);
    chk("b_minsat_wrapped", 32'(wr_b),  1);
    chk("b_minsat_at_min",  32'(min_b), 1);

    // ---- C: N=1 alternates
    rst_c = 1'b0; tick(); tick();
    chk("c_rst_count", 32'(cnt_c), 0);
    rst_c = 1'b1; down_c = 1'b0;
    tick();
    chk("c_count1",   32'(cnt_c), 1);
    chk("c_at_max1",  32'(max_c), 1);
    chk("c_wrapped1", 32'(wr_c),  0);
    tick();
    chk("c_count2",   32'(cnt_c), 0);
    chk("c_wrapped2", 32'(wr_c),  1);
    tick();
    chk("c_count3",   32'(cnt_c), 1);
    down_c = 1'b1;
    tick();
    chk("c_dn_count",   32'(cnt_c), 0);
    chk("c_dn_wrapped", 32'(wr_c),  0);
    tick();
    chk("c_dnwrap_count",   32'(cnt_c), 1);
    chk("c_dnwrap_wrapped", 32'(wr_c),  1);

    // ---- D: N=8 counting down from reset
    rst_d = 1'b0; down_d = 1'b1; tick(); tick();
    chk("d_rst_count", 32'(cnt_d), 0);
    rst_d = 1'b1;
    tick();
    chk("d_count255",  32'(cnt_d), 255);
    chk("d_at_max",    32'(max_d), 1);
    chk("d_wrapped1",  32'(wr_d),  1);
    tick();
    chk("d_count254",  32'(cnt_d), 254);
    chk("d_wrapped2",  32'(wr_d),  0);

    // ---- E: nonzero reset value
    rst_e = 1'b0; tick(); tick();
    chk("e_rst_count",  32'(cnt_e), 200);
    chk("e_rst_at_min", 32'(min_e), 0);
    rst_e = 1'b1; down_e = 1'b0;
    tick();
    chk("e_count201", 32'(cnt_e), 201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parameterised N-bit synchronous up/down counter used as a general-purpose index/address generator in the NTT accelerator datapath. Each clock it steps the count by one in the direction selected by `down`: up when `down`=0, down when `down`=1. It wraps or saturates at the range limits, depending on a parameter. It also provides terminal-count status flags for the control FSMs that consume it.

## Interface

Parameters:
- `N`, default 3: counter width in bits; legal range 1..32.
- `WRAP`, default 1: 1 = modulo-2^N wrap-around at the limits; 0 = saturate at the limits.
- `RESET_VALUE`, default 0: value loaded into `count` on reset; must lie within 0..2^N-1.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `down`, input, 1: direction select; 0 = count up, 1 = count down.
- `count`, output, N: current counter value, registered.
- `at_max`, output, 1: high when `count` = 2^N-1; combinational decode of `count`.
- `at_min`, output, 1: high when `count` = 0; combinational decode of `count`.
- `wrapped`, output, 1: registered one-cycle pulse; high in the cycle after a step that crossed a range limit (wrap or saturation attempt).

## Operation

- The counter counts every cycle; there is no enable. Stepping occurs on every rising `clk` edge where `rst_n`=1.
- Up step (`down`=0): `count` <= `count`+1.
- Down step (`down`=1): `count` <= `count`-1.
- Arithmetic is unsigned, N bits wide; no carry or borrow output other than `wrapped`.
- At the upper limit (`count`=2^N-1, `down`=0):
  - `WRAP`=1: next `count` = 0.
  - `WRAP`=0: `count` holds at 2^N-1.
  - In both cases `wrapped` pulses.
- At the lower limit (`count`=0, `down`=1):
  - `WRAP`=1: next `count` = 2^N-1.
  - `WRAP`=0: `count` holds at 0.
  - In both cases `wrapped` pulses.
- The direction may change in any cycle. The new direction applies to the very next edge, with no dead cycle and no extra step.
- `at_max` and `at_min` are pure decodes of the registered `count`. They are never both high, since N ≥ 1 means 0 ≠ 2^N-1.
- `down` is sampled only at rising edges. Glitches between edges have no effect.
- An X or Z on `down` is not a supported input. Implementations need not define the resulting behaviour.

## Timing

- Step latency: one cycle. The `count` value after edge k reflects `down` as sampled at edge k.
- Reset behaviour:
  - Reset is synchronous. When `rst_n`=0 at a rising edge: `count` <= `RESET_VALUE` and `wrapped` <= 0.
  - `at_max` and `at_min` follow the reset value of `count`.
  - Reset has priority over stepping. Asserting reset mid-count discards the pending step.
- The first step occurs at the first rising edge with `rst_n`=1.
- Before the first reset edge, `count` is undefined. No initial value is required of the RTL.
- `wrapped` timing:
  - High for exactly one cycle, in the cycle following the limit-crossing edge.
  - Held continuously high while the counter keeps hitting a limit: repeated wraps, or saturation with the direction unchanged.
- Combinational paths: none from inputs to outputs. `at_max` and `at_min` depend only on the `count` register.

## Test plan

- Reset: with N=3, hold `rst_n`=0 for 2 edges while `down` toggles. Required: `count`=0, `at_min`=1, `at_max`=0, `wrapped`=0.
- Up wrap: N=3, `WRAP`=1, `down`=0 from reset, 9 edges. Required: `count` = 1,2,…,7,0,1; `at_max` high while `count`=7; `wrapped` high only in the cycle `count`=0.
- Direction change: N=3, count up to 5 then set `down`=1. Required: `count` = 4,3,2,1,0,7,6 on successive edges, with no hold cycle at the turnaround; `wrapped` pulses when `count`=7.
- Saturation: N=3, `WRAP`=0, `down`=0 for 10 edges. Required: `count` reaches 7 and stays at 7; `wrapped` stays high from the first saturated edge. Then `down`=1: `count` = 6 on the next edge and `wrapped` drops.
- Reset mid-count: at `count`=4 with `down`=0, pulse `rst_n`=0 for one edge. Required: `count`=0 (not 5); counting resumes as 1,2,…
- Width sweep: N=1 and N=8 with `WRAP`=1. Required:
  - N=1: `count` alternates 0,1,0.
  - N=8, counting down from reset: `count` goes 0 → 255 → 254.
